// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller driving the 3-sample majority sampler
// Bit timing, frame FSM, LSB-first deserialisation, parity/stop checking and data_valid pulse.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic [5:0]            edge_cnt,
  output logic                  dat_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic [5:0]            r_edge_cnt;
  logic [3:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic [5:0]            r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_busy;

  logic w_wrap;
  logic w_cap;
  logic w_par_exp;

  assign w_wrap    = (r_edge_cnt == (r_prescale - 6'd1));
  // Sampler result lands two cycles after its last sample at the bit midpoint + 1.
  assign w_cap     = (r_edge_cnt == ((r_prescale >> 1) + 6'd3));
  assign w_par_exp = (^r_shift) ^ r_par_typ;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_edge_cnt   <= 6'd0;
      r_bit_cnt    <= 4'd0;
      r_shift      <= '0;
      r_p_data     <= '0;
      r_prescale   <= 6'd0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      if (r_state != S_IDLE) begin
        if (w_wrap) begin
          r_edge_cnt <= 6'd0;
          r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
          r_edge_cnt <= r_edge_cnt + 6'd1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_edge_cnt <= 6'd0;
          r_bit_cnt  <= 4'd0;
          if (!RX_IN) begin
            r_state    <= S_START;
            r_busy     <= 1'b1;
            r_prescale <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
          end
        end
        S_START: begin
          if (w_cap && sampled_bit) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
          end else if (w_wrap) begin
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_cap) begin
            r_shift <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
          end
          // Bit 0 is the start bit, so the last data bit has index DATA_WIDTH.
          if (w_wrap && (r_bit_cnt == 4'(DATA_WIDTH))) begin
            r_state <= r_par_en ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (w_cap) begin
            r_par_err <= (sampled_bit != w_par_exp);
          end
          if (w_wrap) begin
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // Leave at the capture point so a start bit right after the stop bit is not missed.
          if (w_cap) begin
            r_stp_err <= ~sampled_bit;
            if (sampled_bit && !r_par_err) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_edge_cnt <= 6'd0;
            r_bit_cnt  <= 4'd0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_busy     <= 1'b0;
          r_edge_cnt <= 6'd0;
          r_bit_cnt  <= 4'd0;
        end
      endcase
    end
  end

  assign edge_cnt    = r_edge_cnt;
  assign busy        = r_busy;
  assign dat_samp_en = r_busy;
  assign P_DATA      = r_p_data;
  assign data_valid  = r_data_valid;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - scoreboard bench for uart_rx_frame_ctrl with a behavioural majority sampler
module tb_uart_rx_frame_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RX_IN = 1'b1;
  logic [5:0]   Prescale = 6'd8;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         sampled_bit;
  logic [5:0]   edge_cnt;
  logic         dat_samp_en;
  logic [W-1:0] P_DATA;
  logic         data_valid;
  logic         par_err;
  logic         stp_err;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_dv     = 0;
  int cur_p    = 8;

  typedef struct {
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic s0, s1, s2;

  uart_rx_frame_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
    .edge_cnt(edge_cnt), .dat_samp_en(dat_samp_en), .P_DATA(P_DATA),
    .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Majority sampler: samples at half-1, half, half+1; registers the vote at half+2.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      s0 <= 1'b1; s1 <= 1'b1; s2 <= 1'b1; sampled_bit <= 1'b1;
    end else if (dat_samp_en) begin
      if (edge_cnt == 6'(cur_p / 2 - 1)) s0 <= RX_IN;
      if (edge_cnt == 6'(cur_p / 2))     s1 <= RX_IN;
      if (edge_cnt == 6'(cur_p / 2 + 1)) s2 <= RX_IN;
      if (edge_cnt == 6'(cur_p / 2 + 2)) sampled_bit <= (s0 & s1) | (s0 & s2) | (s1 & s2);
    end
  end

  always @(negedge CLK) begin
    if (!RST && data_valid) begin
      n_dv = n_dv + 1;
      n_checks = n_checks + 1;
      if (sb.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL dv_unexpected: P_DATA=%h at cycle %0d, none expected", P_DATA, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (P_DATA !== mon_e.data || cyc != mon_e.cycle) begin
          n_fail = n_fail + 1;
          $display("FAIL dv_word: got %h at cycle %0d, want %h at cycle %0d",
                   P_DATA, cyc, mon_e.data, mon_e.cycle);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic drive_bit(input logic b);
    RX_IN = b;
    tick(cur_p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic pbit, input logic sbit, input logic ok);
    int t0;
    int f;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    Prescale = 6'(cur_p);
    t0 = cyc;
    f  = pe ? 11 : 10;
    if (ok) sb.push_back('{d, t0 + (f - 1) * cur_p + cur_p / 2 + 5});
    RX_IN = 1'b0;
    tick(1);
    n_checks = n_checks + 1;
    if (busy !== 1'b1 || edge_cnt !== 6'd0 || par_err !== 1'b0 || stp_err !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL start_cycle: busy=%b edge_cnt=%0d par_err=%b stp_err=%b, want 1 0 0 0",
               busy, edge_cnt, par_err, stp_err);
    end
    // Scramble configuration mid-frame; the latched copy must be used.
    Prescale = 6'd40;
    PAR_EN   = ~pe;
    PAR_TYP  = ~pt;
    tick(cur_p - 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pe) drive_bit(pbit);
    drive_bit(sbit);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_checks = n_checks + 1;
    if (edge_cnt !== 6'd0 || dat_samp_en !== 1'b0 || P_DATA !== 8'h00 || data_valid !== 1'b0 ||
        par_err !== 1'b0 || stp_err !== 1'b0 || busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_state: edge=%0d en=%b P_DATA=%h dv=%b pe=%b se=%b busy=%b, want all 0",
               edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy);
    end
    tick(2);
    RST = 1'b0;
    tick(4);
    n_checks = n_checks + 1;
    if (busy !== 1'b0 || edge_cnt !== 6'd0) begin
      n_fail = n_fail + 1;
      $display("FAIL idle_hold: busy=%b edge_cnt=%0d, want 0 0", busy, edge_cnt);
    end
  endtask

  task automatic test_parity_good();
    int n0 = n_dv;
    cur_p = 8;
    send_frame(8'hA5, 1'b1, 1'b0, ^8'hA5, 1'b1, 1'b1);
    tick(6);
    n_checks = n_checks + 1;
    if (n_dv - n0 != 1 || par_err !== 1'b0 || stp_err !== 1'b0 || P_DATA !== 8'hA5) begin
      n_fail = n_fail + 1;
      $display("FAIL parity_good: pulses=%0d par_err=%b stp_err=%b P_DATA=%h, want 1 0 0 a5",
               n_dv - n0, par_err, stp_err, P_DATA);
    end
  endtask

  task automatic test_parity_err();
    int n0 = n_dv;
    cur_p = 16;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(6);
    n_checks = n_checks + 1;
    if (n_dv != n0 || par_err !== 1'b1 || stp_err !== 1'b0 || P_DATA !== 8'hA5 || busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL parity_err: pulses=%0d par_err=%b stp_err=%b P_DATA=%h busy=%b, want 0 1 0 a5 0",
               n_dv - n0, par_err, stp_err, P_DATA, busy);
    end
  endtask

  task automatic test_stop_err();
    int n0 = n_dv;
    cur_p = 8;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(4);
    n_checks = n_checks + 1;
    if (n_dv != n0 || stp_err !== 1'b1 || par_err !== 1'b0 || P_DATA !== 8'hA5) begin
      n_fail = n_fail + 1;
      $display("FAIL stop_err: pulses=%0d stp_err=%b par_err=%b P_DATA=%h, want 0 1 0 a5",
               n_dv - n0, stp_err, par_err, P_DATA);
    end
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(6);
    n_checks = n_checks + 1;
    if (n_dv - n0 != 1 || stp_err !== 1'b0 || P_DATA !== 8'h11) begin
      n_fail = n_fail + 1;
      $display("FAIL stop_recover: pulses=%0d stp_err=%b P_DATA=%h, want 1 0 11",
               n_dv - n0, stp_err, P_DATA);
    end
  endtask

  task automatic test_glitch();
    int n0 = n_dv;
    int t0;
    cur_p    = 16;
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    t0 = cyc;
    RX_IN = 1'b0;
    tick(2);
    RX_IN = 1'b1;
    tick(10);
    n_checks = n_checks + 1;
    if (busy !== 1'b1 || edge_cnt !== 6'd11 || cyc != t0 + 12) begin
      n_fail = n_fail + 1;
      $display("FAIL glitch_cap: busy=%b edge_cnt=%0d, want 1 11", busy, edge_cnt);
    end
    tick(1);
    n_checks = n_checks + 1;
    if (busy !== 1'b0 || edge_cnt !== 6'd0 || dat_samp_en !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL glitch_abort: busy=%b edge_cnt=%0d en=%b, want 0 0 0", busy, edge_cnt, dat_samp_en);
    end
    tick(20);
    n_checks = n_checks + 1;
    if (n_dv != n0 || busy !== 1'b0 || P_DATA !== 8'h11) begin
      n_fail = n_fail + 1;
      $display("FAIL glitch_quiet: pulses=%0d busy=%b P_DATA=%h, want 0 0 11", n_dv - n0, busy, P_DATA);
    end
  endtask

  task automatic test_back_to_back();
    int n0 = n_dv;
    cur_p = 32;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(4);
    n_checks = n_checks + 1;
    if (n_dv - n0 != 2 || P_DATA !== 8'hFF || busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL back_to_back: pulses=%0d P_DATA=%h busy=%b, want 2 ff 0", n_dv - n0, P_DATA, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    logic [7:0] d;
    d = 8'h77;
    cur_p    = 8;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    RX_IN = d[4];
    tick(3);
    #2 RST = 1'b1;
    #1;
    n_checks = n_checks + 1;
    if (edge_cnt !== 6'd0 || dat_samp_en !== 1'b0 || P_DATA !== 8'h00 || data_valid !== 1'b0 ||
        par_err !== 1'b0 || stp_err !== 1'b0 || busy !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_async: edge=%0d en=%b P_DATA=%h dv=%b pe=%b se=%b busy=%b, want all 0",
               edge_cnt, dat_samp_en, P_DATA, data_valid, par_err, stp_err, busy);
    end
    @(negedge CLK);
    RX_IN = 1'b1;
    tick(2);
    RST = 1'b0;
    tick(3);
    n0 = n_dv;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(6);
    n_checks = n_checks + 1;
    if (n_dv - n0 != 1 || P_DATA !== 8'hC3 || stp_err !== 1'b0) begin
      n_fail = n_fail + 1;
      $display("FAIL reset_recover: pulses=%0d P_DATA=%h stp_err=%b, want 1 c3 0", n_dv - n0, P_DATA, stp_err);
    end
  endtask

  initial begin
    test_reset();
    test_parity_good();
    test_parity_err();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    n_checks = n_checks + 1;
    if (sb.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL scoreboard_drain: %0d expected words never arrived, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
